bcd_seg_display: RTL and testbench

- Downstream consumer of the 16-bit sequence counters (0-to-40, 350-to-371, 93-to-5, 22525-to-22535).
- Converts the unsigned 16-bit count to 5 BCD digits with a sequential double-dabble engine.
- Drives a board's 8-digit, time-multiplexed, common-anode seven-segment display; digits 0-4 are used and digits 5-7 are held off.

---
 rtl/bcd_seg_display.sv | 175 +++++++++++++++++
 tb/tb_bcd_seg_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed,
// common-anode, 8-digit seven-segment display; digits 0-4 used, 5-7 held off.
module bcd_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic        busy,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [35:0]        shreg_q, shreg_d;
    logic [15:0]        src_q, src_d;
    logic               pending_q, pending_d;
    logic [3:0]         iter_q, iter_d;
    logic [19:0]        bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [35:0] dabble_step(input logic [35:0] r);
        logic [35:0] t;
        t = r;
        for (int i = 0; i < 5; i++) begin
            if (t[16 + 4*i +: 4] >= 4'd5) begin
                t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[34:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        shreg_d     = shreg_q;
        src_d       = src_q;
        pending_d   = pending_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;

        case (state_q)
            IDLE: begin
                if (pending_q || (value != src_q)) begin
                    shreg_d   = {20'd0, value};
                    src_d     = value;
                    pending_d = 1'b0;
                    iter_d    = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = dabble_step(shreg_q);
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d       = shreg_q[35:16];
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    logic [3:0] digit;
    logic       lead_zero;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end

        // A digit is a leading zero when it and every more significant digit are zero.
        digit     = bcd_q[3:0];
        lead_zero = 1'b0;
        case (idx_q)
            3'd1: begin digit = bcd_q[7:4];   lead_zero = (bcd_q[19:4]  == 16'd0); end
            3'd2: begin digit = bcd_q[11:8];  lead_zero = (bcd_q[19:8]  == 12'd0); end
            3'd3: begin digit = bcd_q[15:12]; lead_zero = (bcd_q[19:12] == 8'd0);  end
            3'd4: begin digit = bcd_q[19:16]; lead_zero = (bcd_q[19:16] == 4'd0);  end
            default: begin digit = bcd_q[3:0]; lead_zero = 1'b0; end
        endcase

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (bcd_valid_q && !((BLANK_LZ != 0) && lead_zero)) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = seg_decode(digit);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            src_q       <= '0;
            pending_q   <= 1'b1;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            src_q       <= src_d;
            pending_q   <= pending_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign busy      = busy_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: directed and random conversions checked
// against decimal arithmetic, plus scan/blanking checks on two parameterisations.
module tb_bcd_seg_display;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'd0;

    logic        busy, bcd_valid, dp;
    logic [19:0] bcd;
    logic [7:0]  an;
    logic [6:0]  seg;

    logic        busy_nb, bcd_valid_nb, dp_nb;
    logic [19:0] bcd_nb;
    logic [7:0]  an_nb;
    logic [6:0]  seg_nb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_v    = 0;
    bit exp_valid = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int pow10 [5] = '{1, 10, 100, 1000, 10000};

    bcd_seg_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .value(value), .busy(busy), .bcd(bcd),
        .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
    );

    bcd_seg_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .busy(busy_nb), .bcd(bcd_nb),
        .bcd_valid(bcd_valid_nb), .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    always #5 clk = ~clk;

    // Edges elapsed since the last reset edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
        return r;
    endfunction

    function automatic bit lit(input int v, input bit valid, input int idx, input bit blz);
        return valid && !(blz && idx > 0 && v < pow10[idx]);
    endfunction

    function automatic logic [7:0] exp_an(input int v, input bit valid, input int idx, input bit blz);
        logic [7:0] one;
        one = 8'h01;
        return lit(v, valid, idx, blz) ? ~(one << idx) : 8'hFF;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input bit valid, input int idx, input bit blz);
        return lit(v, valid, idx, blz) ? seg_tab[(v / pow10[idx]) % 10] : 7'h7F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_scan(input int ncyc, input string tag);
        int idx;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            idx = ((cyc - 1) / RDIV) % 5;
            check({tag, " an"},     32'(an),     32'(exp_an(exp_v, exp_valid, idx, 1'b1)));
            check({tag, " seg"},    32'(seg),    32'(exp_seg(exp_v, exp_valid, idx, 1'b1)));
            check({tag, " an_nb"},  32'(an_nb),  32'(exp_an(exp_v, exp_valid, idx, 1'b0)));
            check({tag, " seg_nb"}, 32'(seg_nb), 32'(exp_seg(exp_v, exp_valid, idx, 1'b0)));
            check({tag, " dp"},     32'({dp, dp_nb}), 32'(2'b11));
        end
    endtask

    // Expects the capture at the next edge; optional changes on value mid-conversion.
    task automatic run_conv(input int v_exp, input string tag, input int chg1 = -1, input int chg2 = -1);
        int n;
        bit stable;
        logic [19:0] old;
        old    = to_bcd(exp_v);
        n      = 0;
        stable = 1'b1;
        tick();
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (bcd !== old || busy_nb !== 1'b1) stable = 1'b0;
            if (n == 4 && chg1 >= 0) value = chg1[15:0];
            if (n == 8 && chg2 >= 0) value = chg2[15:0];
            tick();
        end
        check({tag, " busy_cycles"}, 32'(n), 32'd17);
        check({tag, " bcd_held"},    32'(stable), 32'd1);
        check({tag, " bcd"},         32'(bcd), 32'(to_bcd(v_exp)));
        check({tag, " bcd_nb"},      32'(bcd_nb), 32'(to_bcd(v_exp)));
        check({tag, " valid"},       32'({bcd_valid, bcd_valid_nb}), 32'(2'b11));
        exp_v     = v_exp;
        exp_valid = 1'b1;
    endtask

    initial begin
        int r;
        rst   = 1'b1;
        value = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst busy",  32'(busy), 32'd0);
        check("rst bcd",   32'(bcd), 32'd0);
        check("rst valid", 32'(bcd_valid), 32'd0);
        check("rst an",    32'(an), 32'hFF);
        check("rst seg",   32'(seg), 32'h7F);
        check("rst dp",    32'(dp), 32'd1);

        run_conv(0, "zero");
        check_scan(20, "zero");

        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold busy", 32'(busy), 32'd0);
            check("hold bcd",  32'(bcd), 32'd0);
        end

        value = 16'd36;
        run_conv(36, "v36");
        check_scan(20, "v36");

        value = 16'd65535;
        run_conv(65535, "v65535");
        check_scan(20, "v65535");
        value = 16'd22535;
        run_conv(22535, "v22535");
        check_scan(20, "v22535");

        value = 16'd93;
        run_conv(93, "v93", 89, 85);
        run_conv(85, "latest85");
        check_scan(20, "v85");

        value = 16'd371;
        tick();
        check("mid capture busy", 32'(busy), 32'd1);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst bcd",   32'(bcd), 32'd0);
        check("mid rst valid", 32'(bcd_valid), 32'd0);
        check("mid rst an",    32'(an), 32'hFF);
        check("mid rst busy",  32'(busy), 32'd0);
        exp_v     = 0;
        exp_valid = 1'b0;
        run_conv(371, "v371");
        check_scan(20, "v371");

        for (int i = 0; i < 8; i++) begin
            do r = int'($urandom_range(0, 65535)); while (r == exp_v || r == 10000);
            value = r[15:0];
            run_conv(r, "rand");
            check_scan(20, "rand");
        end

        value = 16'd10000;
        run_conv(10000, "v10000");
        check_scan(20, "v10000");
        value = 16'd9;
        run_conv(9, "v9");
        check_scan(20, "v9");
        value = 16'd5;
        run_conv(5, "v5");
        check_scan(40, "v5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
